logic_unit_seq: RTL and testbench

Parametrised, registered successor to the Phase 1 `and_or` unit. It executes eight logic operations on two WIDTH-bit operands behind a start/ready/done handshake. Bitwise operations complete in one cycle at full throughput. Population count runs iteratively over several cycles. The block sits in the datapath ALU slot; the control unit drives `start`, and the result is captured into Z on `done`.

---
 rtl/logic_unit_seq.sv | 131 +++++++++++++
 tb/tb_logic_unit_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Registered eight-operation logic unit with a start/ready/done handshake.
// Bitwise ops finish in one cycle; POPCNT(A) sums CHUNK bits of A per cycle.
module logic_unit_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned AW = $clog2(WIDTH + 1);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_ANDN = 3'd6;
    localparam logic [2:0] OP_POP  = 3'd7;

    typedef enum logic {IDLE, COUNT} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  result_d;
    logic              zero_d;
    logic              done_d;
    logic [WIDTH-1:0]  bitwise;
    logic [CHUNK-1:0]  chunk;
    logic [AW-1:0]     chunk_ones;
    logic [AW-1:0]     sum;

    assign ready = (state_q == IDLE);

    // Single-cycle bitwise result straight from the request inputs
    always_comb begin
        bitwise = '0;
        case (opcode)
            OP_AND:  bitwise = A & B;
            OP_OR:   bitwise = A | B;
            OP_XOR:  bitwise = A ^ B;
            OP_NOR:  bitwise = ~(A | B);
            OP_NAND: bitwise = ~(A & B);
            OP_NOT:  bitwise = ~A;
            OP_ANDN: bitwise = A & ~B;
            default: bitwise = '0;
        endcase
    end

    // Ones count of the current chunk of the latched operand, LSB chunk first
    always_comb begin
        chunk      = CHUNK'(a_q >> (32'(idx_q) * CHUNK));
        chunk_ones = '0;
        for (int unsigned j = 0; j < CHUNK; j++) begin
            chunk_ones = chunk_ones + AW'(chunk[j]);
        end
        sum = acc_q + chunk_ones;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result;
        zero_d   = zero;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (opcode == OP_POP) begin
                        a_d     = A;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = COUNT;
                    end else begin
                        result_d = bitwise;
                        zero_d   = (bitwise == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            COUNT: begin
                acc_d = sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    result_d = WIDTH'(sum);
                    zero_d   = (sum == '0);
                    done_d   = 1'b1;
                    idx_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            result  <= '0;
            zero    <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            result  <= result_d;
            zero    <= zero_d;
            done    <= done_d;
        end
    end
endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: cycle model of the 32/8 instance plus directed
// literal checks, and two small instances for other WIDTH/CHUNK choices.
module tb_logic_unit_seq;
    localparam int TN = 4;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [2:0]  opcode;
    logic [31:0] A, B;
    logic        ready, done, zero;
    logic [31:0] result;

    logic        s16, s8;
    logic [15:0] a16;
    logic [7:0]  a8;
    logic        ready16, done16, zero16, ready8, done8, zero8;
    logic [15:0] result16;
    logic [7:0]  result8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    logic_unit_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clock(clock), .clear(clear), .start(start), .opcode(opcode),
        .A(A), .B(B), .ready(ready), .done(done), .result(result), .zero(zero)
    );

    logic_unit_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clock(clock), .clear(clear), .start(s16), .opcode(3'd7),
        .A(a16), .B(16'h0), .ready(ready16), .done(done16),
        .result(result16), .zero(zero16)
    );

    logic_unit_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clock(clock), .clear(clear), .start(s8), .opcode(3'd7),
        .A(a8), .B(8'h0), .ready(ready8), .done(done8),
        .result(result8), .zero(zero8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bitop(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return ~(a & b);
            3'd5:    return ~a;
            3'd6:    return a & ~b;
            default: return 32'h0;
        endcase
    endfunction

    // Model: a busy countdown while a POPCNT is in flight, $countones at the end
    int          m_busy;
    logic [31:0] m_pa, m_result;
    logic        m_zero, m_done;

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_busy   <= 0;
            m_pa     <= 32'h0;
            m_result <= 32'h0;
            m_zero   <= 1'b1;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy > 0) begin
                if (m_busy == 1) begin
                    m_result <= 32'($countones(m_pa));
                    m_zero   <= (m_pa == 32'h0);
                    m_done   <= 1'b1;
                end
                m_busy <= m_busy - 1;
            end else if (start) begin
                if (opcode == 3'd7) begin
                    m_busy <= TN;
                    m_pa   <= A;
                end else begin
                    m_result <= bitop(opcode, A, B);
                    m_zero   <= (bitop(opcode, A, B) == 32'h0);
                    m_done   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("cyc_ready", 32'(ready), 32'(m_busy == 0));
        check("cyc_done", 32'(done), 32'(m_done));
        check("cyc_result", result, m_result);
        check("cyc_zero", 32'(zero), 32'(m_zero));
    end

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = s;
        opcode = op;
        A      = a;
        B      = b;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    initial begin
        clear = 1'b1;
        s16 = 1'b0; s8 = 1'b0; a16 = 16'h0; a8 = 8'h0;
        start = 1'b1; opcode = 3'd0; A = 32'd7; B = 32'd5;
        @(posedge clock); #1;
        check("rst_ready_held", 32'(ready), 32'd1);
        @(posedge clock); #1;
        check("rst_result", result, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        start = 1'b0;
        clear = 1'b0;

        drive(1'b1, 3'd0, 32'd7, 32'd5);
        check("and_result", result, 32'd5);
        check("and_done", 32'(done), 32'd1);
        idle(1);
        check("and_done_drop", 32'(done), 32'd0);
        drive(1'b1, 3'd1, 32'd6, 32'd2);
        check("or_result", result, 32'd6);
        idle(1);
        drive(1'b1, 3'd2, 32'd7, 32'd5);
        check("xor_result", result, 32'd2);
        idle(1);
        drive(1'b1, 3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("nand_result", result, 32'h0);
        check("nand_zero", 32'(zero), 32'd1);
        idle(1);

        drive(1'b1, 3'd3, 32'h0, 32'h0);
        check("b2b_nor", result, 32'hFFFFFFFF);
        check("b2b_nor_done", 32'(done), 32'd1);
        drive(1'b1, 3'd6, 32'h0000FFFF, 32'h000000FF);
        check("b2b_andn", result, 32'h0000FF00);
        check("b2b_andn_done", 32'(done), 32'd1);
        check("b2b_ready", 32'(ready), 32'd1);
        drive(1'b1, 3'd5, 32'h0000FFFF, 32'h0);
        check("b2b_not", result, 32'hFFFF0000);
        check("b2b_not_done", 32'(done), 32'd1);
        idle(1);
        check("b2b_done_drop", 32'(done), 32'd0);

        drive(1'b1, 3'd7, 32'hFFFFFFFF, 32'h0);
        check("pop_ready_k", 32'(ready), 32'd0);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 3'd0, 32'd7, 32'd5);
            check("pop_ready_busy", 32'(ready), 32'd0);
            check("pop_hold_result", result, 32'hFFFF0000);
            check("pop_no_done", 32'(done), 32'd0);
        end
        idle(1);
        check("pop_ff_result", result, 32'd32);
        check("pop_ff_done", 32'(done), 32'd1);
        check("pop_ff_ready", 32'(ready), 32'd1);
        idle(1);
        check("pop_ff_done_drop", 32'(done), 32'd0);

        drive(1'b1, 3'd7, 32'h80000001, 32'h0);
        idle(4);
        check("pop_81_result", result, 32'd2);
        check("pop_81_zero", 32'(zero), 32'd0);

        drive(1'b1, 3'd7, 32'hFFFFFFFF, 32'h0);
        idle(2);
        #2 clear = 1'b1;
        #1;
        check("abort_result", result, 32'h0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clock); #1;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("abort_no_done", 32'(done), 32'd0);
        end
        drive(1'b1, 3'd0, 32'd3, 32'd1);
        check("post_abort_and", result, 32'd1);

        drive(1'b1, 3'd7, 32'h0, 32'h0);
        idle(4);
        check("pop_0_result", result, 32'h0);
        check("pop_0_zero", 32'(zero), 32'd1);
        check("pop_0_done", 32'(done), 32'd1);
        idle(1);

        s16 = 1'b1; a16 = 16'hF0F0;
        @(posedge clock); #1;
        s16 = 1'b0; a16 = 16'h0;
        for (int i = 1; i < 4; i++) begin
            check("w16_ready_busy", 32'(ready16), 32'd0);
            check("w16_no_done", 32'(done16), 32'd0);
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        check("w16_result", 32'(result16), 32'd8);
        check("w16_done", 32'(done16), 32'd1);
        check("w16_ready", 32'(ready16), 32'd1);

        s8 = 1'b1; a8 = 8'hAA;
        @(posedge clock); #1;
        s8 = 1'b0; a8 = 8'h0;
        check("w8_ready_busy", 32'(ready8), 32'd0);
        check("w8_no_done", 32'(done8), 32'd0);
        @(posedge clock); #1;
        check("w8_result", 32'(result8), 32'd4);
        check("w8_done", 32'(done8), 32'd1);
        check("w8_ready", 32'(ready8), 32'd1);
        check("w8_zero", 32'(zero8), 32'd0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
